cmp_result_monitor: RTL and testbench

//  Downstream consumer of the 2-bit magnitude comparator's a_gt_b/a_lt_b/a_eq_b flags.

---
 rtl/cmp_result_monitor_if.sv | 32 +++
 rtl/cmp_result_monitor.sv | 106 ++++++++++
 tb/tb_cmp_result_monitor.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmp_result_monitor_if.sv
// Bundles the comparator-flag sample stream and the result summary of cmp_result_monitor.
interface cmp_result_monitor_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned RUN_W = 8
);
  logic             start;
  logic             in_valid;
  logic             a_gt_b;
  logic             a_lt_b;
  logic             a_eq_b;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] gt_cnt;
  logic [CNT_W-1:0] lt_cnt;
  logic [CNT_W-1:0] eq_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [RUN_W-1:0] max_eq_run;
  logic             illegal;

  // Sample source and result reader.
  modport master (
    output start, in_valid, a_gt_b, a_lt_b, a_eq_b,
    input  in_ready, busy, done, gt_cnt, lt_cnt, eq_cnt, err_cnt, max_eq_run, illegal
  );

  // The monitor itself.
  modport slave (
    input  start, in_valid, a_gt_b, a_lt_b, a_eq_b,
    output in_ready, busy, done, gt_cnt, lt_cnt, eq_cnt, err_cnt, max_eq_run, illegal
  );
endinterface

// File: rtl/cmp_result_monitor.sv
// Windowed summary of 2-bit comparator result flags: per-class counts, illegal-flag
// count, and the longest run of consecutive EQ samples over WIN accepted samples.
module cmp_result_monitor #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned RUN_W = 8,
  parameter int unsigned WIN   = 16
) (
  input logic                clk,
  input logic                rst_n,
  cmp_result_monitor_if.slave bus
);

  localparam int unsigned SMP_W = $clog2(WIN + 1);
  localparam logic [SMP_W-1:0] LAST_SMP = SMP_W'(WIN - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [SMP_W-1:0] smp_cnt_q;
  logic [CNT_W-1:0] gt_q, lt_q, eq_q, err_q;
  logic [RUN_W-1:0] cur_run_q, max_run_q;
  logic             illegal_q;

  logic             accept;
  logic             is_gt, is_lt, is_eq;
  logic [RUN_W-1:0] run_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Handshake, sample decode and saturating next run length.
  always_comb begin
    accept  = bus.in_valid && (state_q == StRun);
    is_gt   = ({bus.a_gt_b, bus.a_lt_b, bus.a_eq_b} == 3'b100);
    is_lt   = ({bus.a_gt_b, bus.a_lt_b, bus.a_eq_b} == 3'b010);
    is_eq   = ({bus.a_gt_b, bus.a_lt_b, bus.a_eq_b} == 3'b001);
    run_inc = (&cur_run_q) ? cur_run_q : cur_run_q + 1'b1;
  end

  assign bus.in_ready   = (state_q == StRun);
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = (state_q == StDone);
  assign bus.gt_cnt     = gt_q;
  assign bus.lt_cnt     = lt_q;
  assign bus.eq_cnt     = eq_q;
  assign bus.err_cnt    = err_q;
  assign bus.max_eq_run = max_run_q;
  assign bus.illegal    = illegal_q;

  // Window FSM and result registers; results hold after DONE until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      smp_cnt_q <= '0;
      gt_q      <= '0;
      lt_q      <= '0;
      eq_q      <= '0;
      err_q     <= '0;
      cur_run_q <= '0;
      max_run_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q   <= StRun;
            smp_cnt_q <= '0;
            gt_q      <= '0;
            lt_q      <= '0;
            eq_q      <= '0;
            err_q     <= '0;
            cur_run_q <= '0;
            max_run_q <= '0;
            illegal_q <= 1'b0;
          end
        end
        StRun: begin
          if (accept) begin
            smp_cnt_q <= smp_cnt_q + 1'b1;
            if (is_eq) begin
              eq_q      <= sat_inc(eq_q);
              cur_run_q <= run_inc;
              if (run_inc > max_run_q) max_run_q <= run_inc;
            end else begin
              // Any non-EQ accepted sample, legal or not, ends the current EQ run.
              cur_run_q <= '0;
              if (is_gt) begin
                gt_q <= sat_inc(gt_q);
              end else if (is_lt) begin
                lt_q <= sat_inc(lt_q);
              end else begin
                err_q     <= sat_inc(err_q);
                illegal_q <= 1'b1;
              end
            end
            if (smp_cnt_q == LAST_SMP) state_q <= StDone;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_result_monitor.sv
// Randomised self-checking bench for cmp_result_monitor; a CNT_W=3 instance runs in
// parallel on the same stimulus to exercise counter saturation.
module tb_cmp_result_monitor;

  localparam int unsigned WIN = 16;

  typedef struct packed {
    logic [7:0] gt;
    logic [7:0] lt;
    logic [7:0] eq;
    logic [7:0] err;
    logic [7:0] max_run;
    logic       ill;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start, in_valid, f_gt, f_lt, f_eq;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt8 = 0;
  int   done_cnt3 = 0;

  always #5 clk = ~clk;

  cmp_result_monitor_if #(.CNT_W(8), .RUN_W(8)) bus8 ();
  cmp_result_monitor_if #(.CNT_W(3), .RUN_W(8)) bus3 ();

  assign bus8.start    = start;
  assign bus8.in_valid = in_valid;
  assign bus8.a_gt_b   = f_gt;
  assign bus8.a_lt_b   = f_lt;
  assign bus8.a_eq_b   = f_eq;
  assign bus3.start    = start;
  assign bus3.in_valid = in_valid;
  assign bus3.a_gt_b   = f_gt;
  assign bus3.a_lt_b   = f_lt;
  assign bus3.a_eq_b   = f_eq;

  cmp_result_monitor #(.CNT_W(8), .RUN_W(8), .WIN(WIN)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  cmp_result_monitor #(.CNT_W(3), .RUN_W(8), .WIN(WIN)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  // Count done pulses, one per high clock cycle.
  always @(posedge clk) begin
    if (bus8.done) done_cnt8 <= done_cnt8 + 1;
    if (bus3.done) done_cnt3 <= done_cnt3 + 1;
  end

  // Reference: scan the accepted sample list and tally each class; runs of EQ are
  // measured directly as lengths of consecutive EQ entries.
  function automatic res_t model(input logic [2:0] s[$], input int cmax);
    int   gt = 0, lt = 0, eq = 0, err = 0, run = 0, best = 0;
    bit   ill = 0;
    res_t r;
    foreach (s[i]) begin
      if (s[i] == 3'b001) begin
        eq++;
        run++;
        if (run > best) best = run;
      end else begin
        run = 0;
        if (s[i] == 3'b100) gt++;
        else if (s[i] == 3'b010) lt++;
        else begin
          err++;
          ill = 1;
        end
      end
    end
    r.gt      = 8'((gt > cmax) ? cmax : gt);
    r.lt      = 8'((lt > cmax) ? cmax : lt);
    r.eq      = 8'((eq > cmax) ? cmax : eq);
    r.err     = 8'((err > cmax) ? cmax : err);
    r.max_run = 8'((best > 255) ? 255 : best);
    r.ill     = ill;
    return r;
  endfunction

  task automatic snap(output res_t o8, output res_t o3);
    o8.gt = bus8.gt_cnt;  o8.lt = bus8.lt_cnt;  o8.eq = bus8.eq_cnt;  o8.err = bus8.err_cnt;
    o8.max_run = bus8.max_eq_run;  o8.ill = bus8.illegal;
    o3.gt = {5'd0, bus3.gt_cnt};  o3.lt = {5'd0, bus3.lt_cnt};
    o3.eq = {5'd0, bus3.eq_cnt};  o3.err = {5'd0, bus3.err_cnt};
    o3.max_run = bus3.max_eq_run;  o3.ill = bus3.illegal;
  endtask

  task automatic set_flags(input logic [2:0] f);
    {f_gt, f_lt, f_eq} = f;
  endtask

  function automatic logic [2:0] pair_flags(input int a, input int b);
    return (a > b) ? 3'b100 : (a < b) ? 3'b010 : 3'b001;
  endfunction

  // Drives one full window; timing_ok reflects handshake/done behaviour seen on the way.
  task automatic run_window(input logic [2:0] s[$], input int gap_min, input int gap_max,
                            input bit poke_start, output res_t o8, output res_t o3,
                            output bit timing_ok);
    int d8 = done_cnt8;
    int d3 = done_cnt3;
    timing_ok = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    if (!bus8.in_ready || !bus8.busy || bus8.done) timing_ok = 1'b0;
    foreach (s[i]) begin
      repeat ($urandom_range(gap_max, gap_min)) begin
        in_valid = 1'b0;
        set_flags(3'($urandom_range(7, 0)));
        start = poke_start;
        @(negedge clk);
        if (bus8.done || !bus8.in_ready) timing_ok = 1'b0;
      end
      start    = 1'b0;
      in_valid = 1'b1;
      set_flags(s[i]);
      @(negedge clk);
      if (i < s.size() - 1) begin
        if (bus8.done || bus3.done) timing_ok = 1'b0;
      end else begin
        if (!bus8.done || !bus3.done || bus8.in_ready) timing_ok = 1'b0;
      end
    end
    // A GT offered during DONE and the following IDLE cycle must not be counted.
    set_flags(3'b100);
    @(negedge clk);
    if (bus8.done || bus8.busy) timing_ok = 1'b0;
    in_valid = 1'b0;
    if (done_cnt8 - d8 != 1 || done_cnt3 - d3 != 1) timing_ok = 1'b0;
    snap(o8, o3);
  endtask

  task automatic test_reset();
    res_t o8, o3;
    rst_n = 1'b0;
    start = 1'b1;
    in_valid = 1'b1;
    set_flags(3'b001);
    repeat (3) @(negedge clk);
    snap(o8, o3);
    n_checks++;
    if ({o8, o3, bus8.in_ready, bus8.busy, bus8.done} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %h/%h ctl=%b required all zero", o8, o3,
               {bus8.in_ready, bus8.busy, bus8.done});
    end
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    snap(o8, o3);
    n_checks++;
    if ({o8, bus8.in_ready, bus8.busy} !== '0) begin
      n_fail++;
      $display("FAIL idle_ignores_valid: got %h ctl=%b required zero", o8,
               {bus8.in_ready, bus8.busy});
    end
    in_valid = 1'b0;
  endtask

  task automatic test_all_pairs();
    logic [2:0] q[$];
    res_t o8, o3, e8, e3, lit;
    bit   tok;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) q.push_back(pair_flags(a, b));
    run_window(q, 0, 0, 1'b0, o8, o3, tok);
    e8 = model(q, 255);
    e3 = model(q, 7);
    lit = '{gt: 8'd6, lt: 8'd6, eq: 8'd4, err: 8'd0, max_run: 8'd1, ill: 1'b0};
    n_checks += 4;
    if (o8 !== e8) begin n_fail++; $display("FAIL pairs_model8: got %h required %h", o8, e8); end
    if (o8 !== lit) begin n_fail++; $display("FAIL pairs_const: got %h required %h", o8, lit); end
    if (o3 !== e3) begin n_fail++; $display("FAIL pairs_model3: got %h required %h", o3, e3); end
    if (tok !== 1'b1) begin n_fail++; $display("FAIL pairs_timing: got %b required 1", tok); end
  endtask

  task automatic test_all_eq();
    logic [2:0] q[$];
    res_t o8, o3, e8, e3;
    bit   tok;
    repeat (WIN) q.push_back(3'b001);
    run_window(q, 0, 0, 1'b0, o8, o3, tok);
    e8 = model(q, 255);
    e3 = model(q, 7);
    n_checks += 3;
    if (o8 !== e8) begin n_fail++; $display("FAIL alleq_model8: got %h required %h", o8, e8); end
    if (o3 !== e3) begin n_fail++; $display("FAIL alleq_model3: got %h required %h", o3, e3); end
    if (tok !== 1'b1) begin n_fail++; $display("FAIL alleq_timing: got %b required 1", tok); end
  endtask

  task automatic test_illegal_mix();
    logic [2:0] q[$] = '{3'b001, 3'b001, 3'b000, 3'b001, 3'b011, 3'b001, 3'b001, 3'b001};
    res_t o8, o3, e8, lit;
    bit   tok;
    repeat (8) q.push_back(3'b100);
    run_window(q, 0, 1, 1'b0, o8, o3, tok);
    e8 = model(q, 255);
    lit = '{gt: 8'd8, lt: 8'd0, eq: 8'd6, err: 8'd2, max_run: 8'd3, ill: 1'b1};
    n_checks += 3;
    if (o8 !== e8) begin n_fail++; $display("FAIL illegal_model8: got %h required %h", o8, e8); end
    if (o8 !== lit) begin n_fail++; $display("FAIL illegal_const: got %h required %h", o8, lit); end
    if (tok !== 1'b1) begin n_fail++; $display("FAIL illegal_timing: got %b required 1", tok); end
  endtask

  task automatic test_gaps_start();
    logic [2:0] q[$];
    res_t o8, o3, e8;
    bit   tok;
    repeat (WIN) q.push_back(3'b001);
    run_window(q, 1, 3, 1'b1, o8, o3, tok);
    e8 = model(q, 255);
    n_checks += 2;
    if (o8 !== e8) begin n_fail++; $display("FAIL gaps_model8: got %h required %h", o8, e8); end
    if (tok !== 1'b1) begin n_fail++; $display("FAIL gaps_timing: got %b required 1", tok); end
  endtask

  task automatic test_reset_mid();
    res_t o8, o3;
    int   d8 = done_cnt8;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      set_flags((i % 2) ? 3'b001 : 3'b010);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    snap(o8, o3);
    n_checks++;
    if ({o8, o3, bus8.in_ready, bus8.busy, bus8.done} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got %h/%h ctl=%b required all zero", o8, o3,
               {bus8.in_ready, bus8.busy, bus8.done});
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (done_cnt8 !== d8) begin
      n_fail++;
      $display("FAIL reset_mid_nodone: got %0d pulses required %0d", done_cnt8, d8);
    end
    test_all_pairs();
  endtask

  task automatic test_saturate();
    logic [2:0] q[$];
    res_t o8, o3, e3;
    bit   tok;
    repeat (WIN) q.push_back(3'b100);
    run_window(q, 0, 2, 1'b0, o8, o3, tok);
    e3 = model(q, 7);
    n_checks += 3;
    if (o3 !== e3) begin n_fail++; $display("FAIL sat_model3: got %h required %h", o3, e3); end
    if (o3.gt !== 8'd7) begin n_fail++; $display("FAIL sat_gt3: got %0d required 7", o3.gt); end
    if (tok !== 1'b1) begin n_fail++; $display("FAIL sat_timing: got %b required 1", tok); end
  endtask

  task automatic test_random();
    for (int w = 0; w < 6; w++) begin
      logic [2:0] q[$];
      res_t o8, o3, e8, e3;
      bit   tok;
      for (int i = 0; i < WIN; i++) begin
        int r = int'($urandom_range(9, 0));
        if (r < 4) q.push_back(3'b001);
        else if (r < 6) q.push_back(3'b100);
        else if (r < 8) q.push_back(3'b010);
        else q.push_back(3'($urandom_range(7, 0)));
      end
      run_window(q, 0, 2, w[0], o8, o3, tok);
      e8 = model(q, 255);
      e3 = model(q, 7);
      n_checks += 3;
      if (o8 !== e8) begin n_fail++; $display("FAIL rand%0d_model8: got %h required %h", w, o8, e8); end
      if (o3 !== e3) begin n_fail++; $display("FAIL rand%0d_model3: got %h required %h", w, o3, e3); end
      if (tok !== 1'b1) begin n_fail++; $display("FAIL rand%0d_timing: got %b required 1", w, tok); end
    end
  endtask

  initial begin
    start = 1'b0;
    in_valid = 1'b0;
    set_flags(3'b000);
    test_reset();
    test_all_pairs();
    test_all_eq();
    test_illegal_mix();
    test_gaps_start();
    test_reset_mid();
    test_saturate();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a stalled simulation.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
